// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and defaults for the fifo stream reader.
// Holds the FSM state encoding and default data/length widths.
package fifo_stream_reader_pkg;

  localparam int DEF_WSIZE = 32;
  localparam int DEF_LENW  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry in-order word buffer between fifo capture and downstream.
// Ports: clock, reset, push/push_data (capture), pop, occ (0..2), head.
module stream_skid_buffer #(
  parameter int WSIZE = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WSIZE-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WSIZE-1:0] head
);

  logic [WSIZE-1:0] tail;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= push_data;
          else             tail <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        // Push and pop together: occupancy stays, the
        // incoming word lands behind whatever remains.
        2'b11: begin
          if (occ == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a burst of words from a 1-cycle-latency fifo and streams them out.
// Ports: clock, reset, start/burst_len, fifo if, word_out/ready/hold, status.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WSIZE = DEF_WSIZE,
  parameter int LENW  = DEF_LENW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LENW-1:0]  burst_len,
  input  logic [WSIZE-1:0] fifo_data_out,
  input  logic             fifo_empty,
  output logic             fifo_read_en,
  output logic [WSIZE-1:0] word_out,
  output logic             word_ready,
  input  logic             word_out_hold,
  output logic             busy,
  output logic             burst_done,
  output logic [LENW-1:0]  words_sent
);

  localparam logic [LENW-1:0] ONE = LENW'(1);

  state_t          state, state_nx;
  logic [LENW-1:0] len, issued;
  logic            inflight;
  logic            done_q, done_nx;
  logic [1:0]      occ;
  logic            pop, rd, room;
  logic [2:0]      used;

  assign word_ready = (occ != 2'd0);
  assign pop        = word_ready & ~word_out_hold;

  // Words already committed to the buffer (held or in flight),
  // less the one leaving this cycle, must leave a free slot.
  assign used = {1'b0, occ} + {2'b00, inflight};
  assign room = used < (3'd2 + {2'b00, pop});

  assign rd = (state == RUN) & ~fifo_empty
            & (issued < len) & room;

  assign fifo_read_en = rd;
  assign busy         = (state == RUN) | (state == DRAIN);
  assign burst_done   = done_q;

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) state_nx = RUN;
          else                 done_nx  = 1'b1;
        end
      end
      RUN: begin
        if (rd && (issued + ONE == len)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (occ == 2'd0 && !inflight) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      inflight   <= 1'b0;
      len        <= '0;
      issued     <= '0;
      words_sent <= '0;
    end else begin
      state    <= state_nx;
      done_q   <= done_nx;
      inflight <= rd;
      if (state == IDLE && start && burst_len != '0) begin
        len        <= burst_len;
        issued     <= '0;
        words_sent <= '0;
      end else begin
        if (rd)  issued     <= issued + ONE;
        if (pop) words_sent <= words_sent + ONE;
      end
    end
  end

  stream_skid_buffer #(
    .WSIZE(WSIZE)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .push     (inflight),
    .push_data(fifo_data_out),
    .pop      (pop),
    .occ      (occ),
    .head     (word_out)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed + randomized bench for fifo_stream_reader.
// Upstream fifo and output order are modelled with queues.
module tb_fifo_stream_reader;

  localparam int WSIZE = 32;
  localparam int LENW  = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LENW-1:0]  burst_len = '0;
  logic [WSIZE-1:0] fifo_data_out = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_read_en;
  logic [WSIZE-1:0] word_out;
  logic             word_ready;
  logic             word_out_hold = 1'b0;
  logic             busy;
  logic             burst_done;
  logic [LENW-1:0]  words_sent;

  always #5 clock = ~clock;

  fifo_stream_reader #(
    .WSIZE(WSIZE),
    .LENW (LENW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .burst_len    (burst_len),
    .fifo_data_out(fifo_data_out),
    .fifo_empty   (fifo_empty),
    .fifo_read_en (fifo_read_en),
    .word_out     (word_out),
    .word_ready   (word_ready),
    .word_out_hold(word_out_hold),
    .busy         (busy),
    .burst_done   (burst_done),
    .words_sent   (words_sent)
  );

  int ntests = 0;
  int nfail  = 0;

  logic [WSIZE-1:0] fq[$];
  logic [WSIZE-1:0] expq[$];

  logic             start_n = 1'b0;
  logic             hold_n = 1'b0;
  logic [LENW-1:0]  len_n = '0;
  logic             have_rd = 1'b0;
  logic [WSIZE-1:0] rd_word = '0;
  logic [WSIZE-1:0] prev_word = '0;
  bit               prev_held = 1'b0;

  int nrd, nx, ndone, frd, lrd, fx, lx;
  int cc = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    nrd = 0; nx = 0; ndone = 0;
    frd = -1; lrd = -1; fx = -1; lx = -1;
    prev_held = 1'b0;
  endtask

  // One clock: apply queued inputs after the edge,
  // sample and model on the falling edge.
  task automatic cyc();
    bit s_rd, s_x;
    logic [WSIZE-1:0] e;
    @(posedge clock); #1;
    fifo_data_out = have_rd ? rd_word : WSIZE'($urandom);
    have_rd = 1'b0;
    fifo_empty = (fq.size() == 0);
    start = start_n;
    start_n = 1'b0;
    burst_len = len_n;
    word_out_hold = hold_n;
    @(negedge clock);
    cc++;
    s_rd = fifo_read_en;
    s_x  = word_ready && !word_out_hold;
    if (prev_held) begin
      chk("hold_ready", 32'(word_ready), 32'd1);
      chk("hold_head", word_out, prev_word);
    end
    prev_held = word_ready && word_out_hold;
    prev_word = word_out;
    if (busy) chk("words_sent_run", 32'(words_sent), nx);
    if (s_rd) begin
      chk("rd_not_empty", 32'(fifo_empty), 32'd0);
      chk("rd_busy", 32'(busy), 32'd1);
      if (fq.size() > 0) begin
        rd_word = fq.pop_front();
        have_rd = 1'b1;
        expq.push_back(rd_word);
      end
      if (frd < 0) frd = cc;
      lrd = cc;
      nrd++;
    end
    if (s_x) begin
      chk("word_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("word_order", word_out, e);
      end
      if (fx < 0) fx = cc;
      lx = cc;
      nx++;
    end
    chk("outstanding_le2", 32'((nrd - nx) <= 2), 32'd1);
    if (burst_done) ndone++;
  endtask

  task automatic run_burst(int len, int h0, int h1, bit rnd,
                           int late_k, int nlate,
                           int restart_k, int budget);
    int rnd_left;
    int k;
    clear_stats();
    rnd_left = rnd ? len : 0;
    start_n = 1'b1;
    len_n = LENW'(len);
    k = 0;
    while (ndone == 0 && k < budget) begin
      hold_n = (k >= h0 && k <= h1) ||
               (rnd && $urandom_range(0, 2) == 0);
      if (k == late_k)
        repeat (nlate) fq.push_back(WSIZE'($urandom));
      if (rnd_left > 0 && $urandom_range(0, 1) == 1) begin
        fq.push_back(WSIZE'($urandom));
        rnd_left--;
      end
      if (k == restart_k) begin
        start_n = 1'b1;
        len_n = LENW'(3);
      end
      cyc();
      k++;
    end
    hold_n = 1'b0;
    chk("done_seen", ndone, 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("words_sent", 32'(words_sent), len);
    chk("xfer_count", nx, len);
    chk("rd_count", nrd, len);
    cyc();
    chk("done_single", 32'(burst_done), 32'd0);
    chk("words_sent_hold", 32'(words_sent), len);
    chk("all_delivered", expq.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    clear_stats();
    repeat (2) @(negedge clock);
    chk("rst_read_en", 32'(fifo_read_en), 32'd0);
    chk("rst_ready", 32'(word_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(burst_done), 32'd0);
    chk("rst_word", word_out, 32'd0);
    chk("rst_sent", 32'(words_sent), 32'd0);
    reset = 1'b0;
    cyc();

    // Preloaded 0x11..0x14, full speed
    for (int i = 0; i < 4; i++) fq.push_back(WSIZE'(32'h11 + i));
    run_burst(4, -1, -1, 1'b0, -1, 0, -1, 60);
    chk("a_rd_span", lrd - frd + 1, 32'd4);
    chk("a_x_span", lx - fx + 1, 32'd4);

    // Downstream stall in cycles 3..6
    for (int i = 0; i < 8; i++) fq.push_back(WSIZE'($urandom));
    run_burst(8, 3, 6, 1'b0, -1, 0, -1, 100);

    // Fifo runs dry, refilled 5 cycles later
    for (int i = 0; i < 2; i++) fq.push_back(WSIZE'($urandom));
    run_burst(5, -1, -1, 1'b0, 5, 3, -1, 100);

    // Zero-length burst
    fq.push_back(WSIZE'($urandom));
    fq.push_back(WSIZE'($urandom));
    clear_stats();
    start_n = 1'b1;
    len_n = '0;
    cyc();
    chk("z_done_early", 32'(burst_done), 32'd0);
    chk("z_busy0", 32'(busy), 32'd0);
    cyc();
    chk("z_done", 32'(burst_done), 32'd1);
    chk("z_busy1", 32'(busy), 32'd0);
    cyc();
    chk("z_done_once", 32'(burst_done), 32'd0);
    chk("z_no_rd", nrd, 32'd0);

    // Second start during RUN is ignored
    for (int i = 0; i < 4; i++) fq.push_back(WSIZE'($urandom));
    run_burst(6, -1, -1, 1'b0, -1, 0, 3, 100);

    // Reset in the middle of a burst
    for (int i = 0; i < 8; i++) fq.push_back(WSIZE'($urandom));
    clear_stats();
    start_n = 1'b1;
    len_n = LENW'(6);
    k = 0;
    while (nx < 3 && k < 100) begin
      cyc();
      k++;
    end
    chk("r_mid_reached", 32'(nx >= 3), 32'd1);
    reset = 1'b1;
    #1;
    chk("r_read_en", 32'(fifo_read_en), 32'd0);
    chk("r_ready", 32'(word_ready), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_done", 32'(burst_done), 32'd0);
    chk("r_word", word_out, 32'd0);
    chk("r_sent", 32'(words_sent), 32'd0);
    expq.delete();
    clear_stats();
    cyc();
    cyc();
    reset = 1'b0;
    clear_stats();
    cyc();
    run_burst(2, -1, -1, 1'b0, -1, 0, -1, 60);

    // Randomized bursts: random stalls and fifo arrivals
    for (int b = 0; b < 4; b++) begin
      run_burst($urandom_range(1, 10), -1, -1, 1'b1,
                -1, 0, -1, 400);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter WSIZE, default 32, data word width in bits.
REQ-002 Parameter LENW, default 16, width of the burst length and word counters.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  single-cycle pulse; begins a burst (sampled only in IDLE).
REQ-006 burst_len  input  LENW  words to read for this burst; captured on start.
REQ-007 fifo_data_out  input  WSIZE  read data from the upstream fifo.
REQ-008 fifo_empty  input  1  upstream fifo has no words.
REQ-009 fifo_read_en  output  1  read request to the fifo; one word per asserted cycle.
REQ-010 word_out  output  WSIZE  word presented downstream.
REQ-011 word_ready  output  1  word_out is valid.
REQ-012 word_out_hold  input  1  downstream stall; a word transfers on a cycle with word_ready=1 and word_out_hold=0.
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 burst_done  output  1  single-cycle pulse at burst completion.
REQ-015 words_sent  output  LENW  words transferred downstream in the current/last burst.

Function
REQ-016 Fifo read latency: word requested with fifo_read_en=1 (and fifo_empty=0) in cycle N appears on fifo_data_out in cycle N+1 and shall be captured at the end of N+1.
REQ-017 fifo_read_en shall never assert while fifo_empty=1 or outside RUN.
REQ-018 Output buffer: 2 entries, FIFO order; occ in 0..2; inflight = read issued previous cycle.
REQ-019 Issue rule: fifo_read_en = RUN & !fifo_empty & (issued < len) & (occ + inflight - pop < 2), pop = word_ready & !word_out_hold.
REQ-020 Sustained throughput shall be 1 word/cycle when fifo non-empty and hold low; first word reaches word_out 2 cycles after start.
REQ-021 word_ready = (occ > 0); word_out = head entry; head shall not change while held.
REQ-022 Simultaneous capture and pop: occ unchanged, order preserved; no word lost or duplicated.
REQ-023 FSM IDLE: on start with burst_len>0 load len, clear issued and words_sent, go RUN; start with burst_len=0 pulses burst_done next cycle, stays IDLE.
REQ-024 FSM RUN: when issued reaches len go DRAIN; start ignored.
REQ-025 FSM DRAIN: when occ=0 and inflight=0 pulse burst_done, go IDLE.
REQ-026 issued and words_sent increment by one per read / per transfer; no wrap within a burst (len ≤ 2^LENW-1).
REQ-027 words_sent holds its final value in IDLE until next start.
REQ-028 fifo_empty toggling mid-burst shall only pause issue, never drop or reorder words.

Reset
REQ-029 On reset: state IDLE, occ=0, inflight=0, issued=0, words_sent=0; outputs fifo_read_en=0, word_ready=0, busy=0, burst_done=0, word_out=0.
REQ-030 Reset mid-burst shall discard buffered/in-flight words; data returned by the fifo after reset is ignored.

Structure
REQ-031 Shared package holds FSM state constants (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and default WSIZE/LENW.
REQ-032 The 2-entry buffer shall be a sub-module named stream_skid_buffer (push, pop, occ, head data).

Verification
REQ-033 Fifo preloaded 0x11..0x14, start len=4, hold low -> read_en high 4 consecutive cycles, words 0x11..0x14 on consecutive cycles, burst_done once, words_sent=4.
REQ-034 len=8, word_out_hold high cycles 3-6 -> head stable during hold, read_en stalls after occ=2, all 8 words in order, none duplicated.
REQ-035 Fifo starts with 2 words, 3 more written 5 cycles later, len=5 -> read_en never with empty high, 5 words in order, then done.
REQ-036 start with burst_len=0 -> no read_en, burst_done one cycle later, busy stays 0.
REQ-037 reset asserted in RUN after 3 of 6 words -> all outputs zero immediately; new start len=2 after reset reads the next fifo words correctly.
REQ-038 start pulsed again during RUN -> ignored; words_sent and len unchanged.
